nem_ohmux_seq: RTL and testbench

Parametrised, sequenced successor to the fixed 4-input, 8-bit NEM one-hot inverting mux. It adds a select controller that drives the relay gate lines with break-before-make ordering and programmable mechanical settle times. It also flags when the output is trustworthy. It sits between configuration logic, which issues select requests, and the relay-based routing array: `S` drives relay gates and `ZN` is the inverted selected data word.

---
 rtl/nem_ohmux_seq.sv | 141 ++++++++++++++
 tb/tb_nem_ohmux_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nem_ohmux_seq.sv
// NEM one-hot inverting mux with a break-before-make relay select sequencer.
// S and VALID are registered from the next state, so they always agree with the FSM.
module nem_ohmux_seq #(
   parameter int N_IN    = 4,
   parameter int WIDTH   = 8,
   parameter int T_BREAK = 2,
   parameter int T_MAKE  = 3,
   parameter int SELW    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                  CP,
   input  logic                  CDN,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic                  REQ_EN,
   input  logic [SELW-1:0]       REQ_SEL,
   input  logic [N_IN*WIDTH-1:0] I,
   output logic [N_IN-1:0]       S,
   output logic [WIDTH-1:0]      ZN,
   output logic                  VALID,
   output logic                  ERR,
   output logic [15:0]           SW_CNT
);
   localparam int CMAX = (T_BREAK > T_MAKE) ? T_BREAK : T_MAKE;
   localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CNTW-1:0] BREAK_LD = CNTW'(T_BREAK - 1);
   localparam logic [CNTW-1:0] MAKE_LD  = CNTW'(T_MAKE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_MAKE, ST_ON} state_t;

   state_t          state, state_nx;
   logic [SELW-1:0] sel_q, sel_nx;
   logic [CNTW-1:0] cnt, cnt_nx;
   logic            dis_q, dis_nx;
   logic [N_IN-1:0] s_nx;
   logic            accept, sel_ok, reject, made;
   logic [15:0]     sw_cnt;
   logic [WIDTH-1:0] or_acc;

   assign REQ_READY = (state == ST_IDLE) || (state == ST_ON);
   assign accept    = REQ_VALID && REQ_READY;
   assign sel_ok    = 32'(REQ_SEL) < 32'(N_IN);
   assign SW_CNT    = sw_cnt;

   always_comb begin
      state_nx = state;
      sel_nx   = sel_q;
      cnt_nx   = cnt;
      dis_nx   = dis_q;
      reject   = 1'b0;
      made     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept && REQ_EN) begin
               if (!sel_ok) begin
                  reject = 1'b1;
               end else begin
                  sel_nx   = REQ_SEL;
                  state_nx = ST_MAKE;
                  cnt_nx   = MAKE_LD;
               end
            end
         end
         ST_ON: begin
            if (accept) begin
               if (REQ_EN && !sel_ok) begin
                  reject = 1'b1;
               end else if (!REQ_EN) begin
                  state_nx = ST_BREAK;
                  cnt_nx   = BREAK_LD;
                  dis_nx   = 1'b1;
               end else if (REQ_SEL != sel_q) begin
                  sel_nx   = REQ_SEL;
                  state_nx = ST_BREAK;
                  cnt_nx   = BREAK_LD;
                  dis_nx   = 1'b0;
               end
            end
         end
         ST_BREAK: begin
            if (cnt == '0) begin
               if (dis_q) begin
                  state_nx = ST_IDLE;
                  dis_nx   = 1'b0;
               end else begin
                  state_nx = ST_MAKE;
                  cnt_nx   = MAKE_LD;
               end
            end else begin
               cnt_nx = cnt - CNTW'(1);
            end
         end
         ST_MAKE: begin
            if (cnt == '0) begin
               state_nx = ST_ON;
               made     = 1'b1;
            end else begin
               cnt_nx = cnt - CNTW'(1);
            end
         end
      endcase

      s_nx = '0;
      if (state_nx == ST_MAKE || state_nx == ST_ON) begin
         for (int unsigned k = 0; k < N_IN; k++) begin
            s_nx[k] = (sel_nx == SELW'(k));
         end
      end
   end

   always_ff @(posedge CP or negedge CDN) begin
      if (!CDN) begin
         state  <= ST_IDLE;
         sel_q  <= '0;
         cnt    <= '0;
         dis_q  <= 1'b0;
         S      <= '0;
         VALID  <= 1'b0;
         ERR    <= 1'b0;
         sw_cnt <= '0;
      end else begin
         state <= state_nx;
         sel_q <= sel_nx;
         cnt   <= cnt_nx;
         dis_q <= dis_nx;
         S     <= s_nx;
         VALID <= (state_nx == ST_ON);
         ERR   <= reject;
         if (made && sw_cnt != '1) begin
            sw_cnt <= sw_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      or_acc = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
         or_acc = or_acc | ({WIDTH{S[k]}} & I[k*WIDTH +: WIDTH]);
      end
      ZN = ~or_acc;
   end
endmodule

// File: tb/tb_nem_ohmux_seq.sv
// Bench for nem_ohmux_seq: three configurations checked against a
// cycles-since-accept timeline model of the relay sequencing.
module tb_nem_ohmux_seq;
   localparam int K_MAKE = 0, K_SW = 1, K_DIS = 2, K_HOLD = 3;
   localparam int unsigned TBK [3] = '{2, 2, 1};
   localparam int unsigned TMK [3] = '{3, 3, 1};

   logic CP, CDN;

   logic        v4, en4, rdy4, val4, err4;
   logic [1:0]  sel4;
   logic [31:0] i4;
   logic [3:0]  s4;
   logic [7:0]  zn4;
   logic [15:0] cnt4;

   logic        v5, en5, rdy5, val5, err5;
   logic [2:0]  sel5;
   logic [39:0] i5;
   logic [4:0]  s5;
   logic [7:0]  zn5;
   logic [15:0] cnt5;

   logic         v16, en16, rdy16, val16, err16;
   logic [3:0]   sel16;
   logic [511:0] i16;
   logic [15:0]  s16;
   logic [31:0]  zn16;
   logic [15:0]  cnt16;

   logic [31:0] dat [3][16];
   int unsigned made [3];
   int unsigned cur_sel [3];
   logic        is_on [3];
   int unsigned n_checks, n_pass, n_fail;

   nem_ohmux_seq u4 (
      .CP(CP), .CDN(CDN), .REQ_VALID(v4), .REQ_READY(rdy4), .REQ_EN(en4), .REQ_SEL(sel4),
      .I(i4), .S(s4), .ZN(zn4), .VALID(val4), .ERR(err4), .SW_CNT(cnt4));

   nem_ohmux_seq #(.N_IN(5)) u5 (
      .CP(CP), .CDN(CDN), .REQ_VALID(v5), .REQ_READY(rdy5), .REQ_EN(en5), .REQ_SEL(sel5),
      .I(i5), .S(s5), .ZN(zn5), .VALID(val5), .ERR(err5), .SW_CNT(cnt5));

   nem_ohmux_seq #(.N_IN(16), .WIDTH(32), .T_BREAK(1), .T_MAKE(1)) u16 (
      .CP(CP), .CDN(CDN), .REQ_VALID(v16), .REQ_READY(rdy16), .REQ_EN(en16), .REQ_SEL(sel16),
      .I(i16), .S(s16), .ZN(zn16), .VALID(val16), .ERR(err16), .SW_CNT(cnt16));

   always_comb begin
      i4  = '0;
      i5  = '0;
      i16 = '0;
      for (int k = 0; k < 4; k++)  i4[k*8 +: 8]    = dat[0][k][7:0];
      for (int k = 0; k < 5; k++)  i5[k*8 +: 8]    = dat[1][k][7:0];
      for (int k = 0; k < 16; k++) i16[k*32 +: 32] = dat[2][k];
   end

   initial CP = 1'b0;
   always #5 CP = ~CP;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int unsigned u, input logic v, input logic en, input logic [3:0] sel);
      case (u)
         0: begin v4 = v;  en4 = en;  sel4 = sel[1:0];  end
         1: begin v5 = v;  en5 = en;  sel5 = sel[2:0];  end
         default: begin v16 = v; en16 = en; sel16 = sel; end
      endcase
   endtask

   task automatic sample(input int unsigned u, output logic [15:0] s, output logic [31:0] zn,
                         output logic rdy, output logic val, output logic err, output logic [15:0] cnt);
      case (u)
         0: begin s = 16'(s4); zn = 32'(zn4); rdy = rdy4; val = val4; err = err4; cnt = cnt4; end
         1: begin s = 16'(s5); zn = 32'(zn5); rdy = rdy5; val = val5; err = err5; cnt = cnt5; end
         default: begin s = s16; zn = zn16; rdy = rdy16; val = val16; err = err16; cnt = cnt16; end
      endcase
   endtask

   // Inverted mux reference: an open path reads all ones, else the inverted selected word.
   function automatic logic [31:0] exp_zn(input int unsigned u, input logic s_on, input int unsigned sel);
      logic [31:0] m;
      m = (u == 2) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      return s_on ? (~dat[u][sel] & m) : m;
   endfunction

   task automatic req(input int unsigned u, input logic en, input logic [3:0] sel);
      @(negedge CP);
      drive(u, 1'b1, en, sel);
      @(posedge CP);
      #1 drive(u, 1'b0, 1'b0, 4'd0);
   endtask

   // Checks every cycle after the accepting edge (j=0) until the sequence settles.
   task automatic track(input int unsigned u, input int kind, input int unsigned sel, input logic err_exp);
      int unsigned tb, tm, last, nsel, cexp;
      logic s_on, v_on, r_on;
      logic [15:0] s, cnt;
      logic [31:0] zn;
      logic rdy, val, err;
      string tag;
      tb = TBK[u];
      tm = TMK[u];
      case (kind)
         K_MAKE:  last = tm;
         K_SW:    last = tb + tm;
         K_DIS:   last = tb;
         default: last = 2;
      endcase
      nsel = (kind == K_HOLD) ? cur_sel[u] : sel;
      for (int unsigned j = 0; j <= last; j++) begin
         @(negedge CP);
         case (kind)
            K_MAKE:  begin s_on = 1'b1;    v_on = (j >= tm);      end
            K_SW:    begin s_on = (j >= tb); v_on = (j >= tb + tm); end
            K_DIS:   begin s_on = 1'b0;    v_on = 1'b0;           end
            default: begin s_on = is_on[u]; v_on = is_on[u];      end
         endcase
         r_on = (kind == K_DIS) ? (j >= tb) : ((kind == K_HOLD) ? 1'b1 : v_on);
         cexp = made[u] + (((kind == K_MAKE || kind == K_SW) && v_on) ? 1 : 0);
         if (cexp > 65535) cexp = 65535;
         sample(u, s, zn, rdy, val, err, cnt);
         tag = $sformatf("u%0d.k%0d.sel%0d.j%0d", u, kind, nsel, j);
         chk($sformatf("%s.S", tag), 64'(s), s_on ? 64'(16'h1 << nsel) : 64'd0);
         chk($sformatf("%s.onehot0", tag), 64'($onehot0(s)), 64'd1);
         chk($sformatf("%s.VALID", tag), 64'(val), 64'(v_on));
         chk($sformatf("%s.READY", tag), 64'(rdy), 64'(r_on));
         chk($sformatf("%s.ERR", tag), 64'(err), (j == 0) ? 64'(err_exp) : 64'd0);
         chk($sformatf("%s.SW_CNT", tag), 64'(cnt), 64'(cexp));
         chk($sformatf("%s.ZN", tag), 64'(zn), 64'(exp_zn(u, s_on, nsel)));
      end
      case (kind)
         K_MAKE, K_SW: begin
            if (made[u] < 65535) made[u]++;
            is_on[u]   = 1'b1;
            cur_sel[u] = sel;
         end
         K_DIS: is_on[u] = 1'b0;
         default: ;
      endcase
   endtask

   task automatic check_reset(input int unsigned u, input string tag);
      logic [15:0] s, cnt;
      logic [31:0] zn;
      logic rdy, val, err;
      sample(u, s, zn, rdy, val, err, cnt);
      chk($sformatf("%s.u%0d.S", tag, u), 64'(s), 64'd0);
      chk($sformatf("%s.u%0d.VALID", tag, u), 64'(val), 64'd0);
      chk($sformatf("%s.u%0d.READY", tag, u), 64'(rdy), 64'd1);
      chk($sformatf("%s.u%0d.ERR", tag, u), 64'(err), 64'd0);
      chk($sformatf("%s.u%0d.SW_CNT", tag, u), 64'(cnt), 64'd0);
      chk($sformatf("%s.u%0d.ZN", tag, u), 64'(zn), 64'(exp_zn(u, 1'b0, 0)));
      made[u]  = 0;
      is_on[u] = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_fail   = 0;
      for (int u = 0; u < 3; u++) begin
         made[u]    = 0;
         cur_sel[u] = 0;
         is_on[u]   = 1'b0;
         drive(u, 1'b0, 1'b0, 4'd0);
         for (int k = 0; k < 16; k++) dat[u][k] = $urandom;
      end
      CDN = 1'b1;
      #1 CDN = 1'b0;
      repeat (2) @(posedge CP);
      @(negedge CP);
      for (int unsigned u = 0; u < 3; u++) check_reset(u, "por");
      CDN = 1'b1;

      // Default configuration: make from IDLE, switch, repeat, held request.
      dat[0][2] = 32'h0000_00A5;
      req(0, 1'b1, 4'd2);
      track(0, K_MAKE, 2, 1'b0);
      chk("u0.zn_a5", 64'(zn4), 64'h5A);
      chk("u0.swcnt_first", 64'(cnt4), 64'd1);

      req(0, 1'b1, 4'd0);
      track(0, K_SW, 0, 1'b0);
      dat[0][0] = $urandom;
      #1 chk("u0.zn_follows_i", 64'(zn4), 64'(8'(~dat[0][0])));

      req(0, 1'b1, 4'd0);
      track(0, K_HOLD, 0, 1'b0);

      @(negedge CP);
      drive(0, 1'b1, 1'b1, 4'd1);
      @(posedge CP);
      #1 drive(0, 1'b1, 1'b1, 4'd3);
      track(0, K_SW, 1, 1'b0);
      @(posedge CP);
      #1 drive(0, 1'b0, 1'b0, 4'd0);
      track(0, K_SW, 3, 1'b0);

      // Five inputs: out-of-range rejection, disable, IDLE no-ops.
      req(1, 1'b1, 4'd4);
      track(1, K_MAKE, 4, 1'b0);
      req(1, 1'b1, 4'd6);
      track(1, K_HOLD, 0, 1'b1);
      req(1, 1'b1, 4'd5);
      track(1, K_HOLD, 0, 1'b1);
      req(1, 1'b0, 4'd0);
      track(1, K_DIS, 0, 1'b0);
      chk("u1.zn_open", 64'(zn5), 64'hFF);
      req(1, 1'b1, 4'd7);
      track(1, K_HOLD, 0, 1'b1);
      req(1, 1'b0, 4'd2);
      track(1, K_HOLD, 0, 1'b0);

      // Sixteen wide inputs, single-cycle phases: visit every select.
      for (int unsigned k = 0; k < 16; k++) begin
         for (int w = 0; w < 16; w++) dat[2][w] = $urandom;
         req(2, 1'b1, 4'(k));
         track(2, (k == 0) ? K_MAKE : K_SW, k, 1'b0);
      end

      // Preload the make counter near its ceiling and run past it.
      @(negedge CP);
      force u16.sw_cnt = 16'hFFFD;
      #1 release u16.sw_cnt;
      made[2] = 65533;
      #1 chk("u2.preload", 64'(cnt16), 64'hFFFD);
      for (int unsigned k = 0; k < 4; k++) begin
         req(2, 1'b1, 4'((k * 5 + 3) % 16));
         track(2, K_SW, (k * 5 + 3) % 16, 1'b0);
      end
      chk("u2.saturated", 64'(cnt16), 64'hFFFF);

      // Asynchronous reset in the middle of a make.
      req(0, 1'b1, 4'd1);
      repeat (3) @(negedge CP);
      chk("u0.premake_s", 64'(s4), 64'h2);
      chk("u0.premake_valid", 64'(val4), 64'd0);
      #2 CDN = 1'b0;
      #1 for (int unsigned u = 0; u < 3; u++) check_reset(u, "midmake");
      #1 CDN = 1'b1;
      drive(0, 1'b1, 1'b1, 4'd2);
      @(posedge CP);
      #1 drive(0, 1'b0, 1'b0, 4'd0);
      track(0, K_MAKE, 2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
